// File: rtl/fifo_flush_pkg.sv
// Shared types and constants for the flush-FIFO drain/unpack block.
package fifo_flush_pkg;

  localparam int NIBBLE_W    = 4;
  localparam int WORD_W      = 32;
  localparam int MAX_NIBBLES = 8;
  // Width of the upstream occupancy count (0..8, larger values possible on the wire)
  localparam int CURR_W      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Clamp an upstream nibble count to the number of nibbles a word can hold
  function automatic logic [CURR_W-1:0] sat_nibbles(input logic [CURR_W-1:0] curr);
    if (curr > CURR_W'(MAX_NIBBLES)) begin
      return CURR_W'(MAX_NIBBLES);
    end
    return curr;
  endfunction

endpackage

// File: rtl/flush_idle_timer.sv
// Idle timer: counts idle cycles with a partly filled upstream FIFO and
// flags when the forced-flush limit has been reached. Saturates at the limit.
module flush_idle_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic rclock,
  input  logic reset,
  input  logic clear,
  input  logic advance,
  output logic expired
);

  localparam int TIMER_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(TIMEOUT);

  logic [TIMER_W-1:0] timer_reg;

  // Count qualifying idle cycles; clear has priority, hold once the limit is hit
  always_ff @(posedge rclock or negedge reset) begin
    if (!reset) begin
      timer_reg <= '0;
    end else if (clear) begin
      timer_reg <= '0;
    end else if (advance && (timer_reg != LIMIT)) begin
      timer_reg <= timer_reg + TIMER_W'(1);
    end
  end

  assign expired = (timer_reg == LIMIT);

endmodule

// File: rtl/fifo_drain_unpack.sv
// Requests flushes from an upstream nibble FIFO, captures the packed flush
// word and streams it out one nibble per beat (oldest nibble first) over a
// valid/ready interface. Only one flushed word is ever in flight.
module fifo_drain_unpack
  import fifo_flush_pkg::*;
#(
  parameter int THRESH    = 4,
  parameter int TIMEOUT   = 16,
  parameter int FLUSH_LAT = 2
) (
  input  logic                rclock,
  input  logic                reset,
  input  logic                fifo_empty_i,
  input  logic [CURR_W-1:0]   fifo_curr_i,
  input  logic [WORD_W-1:0]   fifo_rd_data_i,
  output logic                fifo_flush_o,
  output logic                out_valid_o,
  output logic [NIBBLE_W-1:0] out_data_o,
  output logic                out_last_o,
  input  logic                out_ready_i,
  output logic                busy_o,
  output logic [7:0]          flush_cnt_o
);

  // The flushed word is valid FLUSH_LAT cycles after the pulse; WAIT spans
  // exactly those cycles so its final cycle sees the valid word and the first
  // beat appears FLUSH_LAT+1 cycles after the FLUSH cycle.
  localparam int WAIT_W = (FLUSH_LAT > 1) ? $clog2(FLUSH_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = (FLUSH_LAT > 1) ? WAIT_W'(FLUSH_LAT - 1) : '0;
  localparam logic [CURR_W:0] THRESH_V = (CURR_W + 1)'(THRESH);

  state_t              state_reg;
  state_t              state_next;
  logic                armed_reg;
  logic [CURR_W-1:0]   count_reg;
  logic [WORD_W-1:0]   shreg_reg;
  logic [WAIT_W-1:0]   wait_cnt_reg;
  logic [7:0]          flush_cnt_reg;

  logic                at_thresh;
  logic                timer_expired;
  logic                timer_clear;
  logic                timer_advance;
  logic                wait_done;
  logic                beat_last;
  logic                beat_take;

  assign at_thresh     = ({1'b0, fifo_curr_i} >= THRESH_V);
  assign wait_done     = (state_reg == WAIT) && (wait_cnt_reg == WAIT_LAST);
  assign beat_last     = (count_reg == CURR_W'(1));
  assign beat_take     = (state_reg == DRAIN) && out_ready_i;
  assign timer_clear   = (state_reg != IDLE) || fifo_empty_i;
  assign timer_advance = (state_reg == IDLE) && !fifo_empty_i && !at_thresh;

  flush_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .rclock  (rclock),
    .reset   (reset),
    .clear   (timer_clear),
    .advance (timer_advance),
    .expired (timer_expired)
  );

  // Hold off flush decisions for the first edge after reset release
  always_ff @(posedge rclock or negedge reset) begin
    if (!reset) begin
      armed_reg <= 1'b0;
    end else begin
      armed_reg <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge rclock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (armed_reg && !fifo_empty_i && (at_thresh || timer_expired)) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        state_next = WAIT;
      end
      WAIT: begin
        if (wait_done) begin
          state_next = (count_reg == '0) ? IDLE : DRAIN;
        end
      end
      DRAIN: begin
        if (out_ready_i && beat_last) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM outputs; data and last are held because count/shreg only move on a taken beat
  always_comb begin
    fifo_flush_o = (state_reg == FLUSH);
    out_valid_o  = (state_reg == DRAIN);
    out_data_o   = (state_reg == DRAIN) ? shreg_reg[NIBBLE_W-1:0] : '0;
    out_last_o   = (state_reg == DRAIN) && beat_last;
    busy_o       = (state_reg != IDLE);
    flush_cnt_o  = flush_cnt_reg;
  end

  // Remaining-nibble count: latched on the flush, decremented per taken beat
  always_ff @(posedge rclock or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (state_reg == FLUSH) begin
      count_reg <= sat_nibbles(fifo_curr_i);
    end else if (beat_take) begin
      count_reg <= count_reg - CURR_W'(1);
    end
  end

  // Wait-phase cycle counter, restarted on every flush
  always_ff @(posedge rclock or negedge reset) begin
    if (!reset) begin
      wait_cnt_reg <= '0;
    end else if (state_reg == FLUSH) begin
      wait_cnt_reg <= '0;
    end else if (state_reg == WAIT) begin
      wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
    end
  end

  // Shift register: load the flushed word, then shift one nibble per taken beat
  always_ff @(posedge rclock or negedge reset) begin
    if (!reset) begin
      shreg_reg <= '0;
    end else if (wait_done) begin
      shreg_reg <= fifo_rd_data_i;
    end else if (beat_take) begin
      shreg_reg <= {{NIBBLE_W{1'b0}}, shreg_reg[WORD_W-1:NIBBLE_W]};
    end
  end

  // Count issued flushes, wrapping naturally at 8 bits
  always_ff @(posedge rclock or negedge reset) begin
    if (!reset) begin
      flush_cnt_reg <= '0;
    end else if (state_reg == FLUSH) begin
      flush_cnt_reg <= flush_cnt_reg + 8'd1;
    end
  end

endmodule

// File: tb/tb_fifo_drain_unpack.sv
// Directed bench for fifo_drain_unpack with default parameters
// (THRESH=4, TIMEOUT=16, FLUSH_LAT=2).
module tb_fifo_drain_unpack;

  logic        rclock;
  logic        reset;
  logic        fifo_empty_i;
  logic [3:0]  fifo_curr_i;
  logic [31:0] fifo_rd_data_i;
  logic        fifo_flush_o;
  logic        out_valid_o;
  logic [3:0]  out_data_o;
  logic        out_last_o;
  logic        out_ready_i;
  logic        busy_o;
  logic [7:0]  flush_cnt_o;

  int tests_run = 0;
  int tests_failed = 0;

  fifo_drain_unpack dut (
    .rclock         (rclock),
    .reset          (reset),
    .fifo_empty_i   (fifo_empty_i),
    .fifo_curr_i    (fifo_curr_i),
    .fifo_rd_data_i (fifo_rd_data_i),
    .fifo_flush_o   (fifo_flush_o),
    .out_valid_o    (out_valid_o),
    .out_data_o     (out_data_o),
    .out_last_o     (out_last_o),
    .out_ready_i    (out_ready_i),
    .busy_o         (busy_o),
    .flush_cnt_o    (flush_cnt_o)
  );

  initial rclock = 1'b0;
  always #5 rclock = ~rclock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclock);
    #1;
  endtask

  // Step until the flush pulse shows up; check it did and how many edges it took
  task automatic wait_flush(input string tag, input int exp_cycles);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!fifo_flush_o && n < 64);
    check_eq({tag, "_flush"}, 32'(fifo_flush_o), 32'd1);
    check_eq({tag, "_lat"}, 32'(n), 32'(exp_cycles));
    $display("[TB] %s flush after %0d cycles, flush_cnt=%0d", tag, n, flush_cnt_o);
  endtask

  // Called in the FLUSH cycle: upstream goes empty, two silent WAIT cycles,
  // then returns at the first DRAIN cycle
  task automatic start_drain(input string tag);
    tick();
    fifo_empty_i = 1'b1;
    fifo_curr_i  = 4'd0;
    check_eq({tag, "_pulse1"}, 32'(fifo_flush_o), 32'd0);
    check_eq({tag, "_wait1"}, 32'(out_valid_o), 32'd0);
    tick();
    check_eq({tag, "_wait2"}, 32'(out_valid_o), 32'd0);
    tick();
  endtask

  // Expect n beats taken with ready high, nibble i of word on beat i
  task automatic expect_beats(input string tag, input logic [31:0] word, input int n);
    logic [3:0] e;
    for (int i = 0; i < n; i++) begin
      e = word[4*i +: 4];
      $display("[TB] %s beat %0d data=%h last=%b", tag, i, out_data_o, out_last_o);
      check_eq({tag, "_valid"}, 32'(out_valid_o), 32'd1);
      check_eq({tag, "_data"}, 32'(out_data_o), 32'(e));
      check_eq({tag, "_last"}, 32'(out_last_o), (i == n - 1) ? 32'd1 : 32'd0);
      tick();
    end
    check_eq({tag, "_end"}, 32'(out_valid_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    reset          = 1'b0;
    fifo_empty_i   = 1'b1;
    fifo_curr_i    = 4'd0;
    fifo_rd_data_i = 32'h0;
    out_ready_i    = 1'b1;
    repeat (2) tick();
    check_eq("rst_flush", 32'(fifo_flush_o), 32'd0);
    check_eq("rst_valid", 32'(out_valid_o), 32'd0);
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    check_eq("rst_cnt", 32'(flush_cnt_o), 32'd0);

    // Threshold flush right after release: pulse no earlier than 2nd edge
    fifo_empty_i   = 1'b0;
    fifo_curr_i    = 4'd4;
    fifo_rd_data_i = 32'h0000_5A3C;
    reset          = 1'b1;
    wait_flush("thr", 2);
    check_eq("thr_busy", 32'(busy_o), 32'd1);
    start_drain("thr");
    expect_beats("thr", 32'h0000_5A3C, 4);
    check_eq("thr_cnt", 32'(flush_cnt_o), 32'd1);
    check_eq("thr_idle", 32'(busy_o), 32'd0);

    // Timeout flush: 2 nibbles, non-empty, now in IDLE with cleared timer
    fifo_empty_i   = 1'b0;
    fifo_curr_i    = 4'd2;
    fifo_rd_data_i = 32'h0000_00B7;
    wait_flush("tmo", 17);
    start_drain("tmo");
    expect_beats("tmo", 32'h0000_00B7, 2);
    check_eq("tmo_cnt", 32'(flush_cnt_o), 32'd2);

    // Backpressure on beat 2 for 3 cycles
    fifo_empty_i   = 1'b0;
    fifo_curr_i    = 4'd4;
    fifo_rd_data_i = 32'h0000_4321;
    wait_flush("bp", 1);
    start_drain("bp");
    check_eq("bp_b1", 32'(out_data_o), 32'h1);
    tick();
    check_eq("bp_b2", 32'(out_data_o), 32'h2);
    out_ready_i = 1'b0;
    repeat (2) begin
      tick();
      $display("[TB] bp stall data=%h last=%b", out_data_o, out_last_o);
      check_eq("bp_hold_valid", 32'(out_valid_o), 32'd1);
      check_eq("bp_hold_data", 32'(out_data_o), 32'h2);
      check_eq("bp_hold_last", 32'(out_last_o), 32'd0);
    end
    out_ready_i = 1'b1;
    tick();
    expect_beats("bp_tail", 32'h0000_0043, 2);
    check_eq("bp_cnt", 32'(flush_cnt_o), 32'd3);

    // Full word, then overrange count that must saturate to 8
    fifo_empty_i   = 1'b0;
    fifo_curr_i    = 4'd8;
    fifo_rd_data_i = 32'h8765_4321;
    wait_flush("full", 1);
    start_drain("full");
    expect_beats("full", 32'h8765_4321, 8);
    fifo_empty_i   = 1'b0;
    fifo_curr_i    = 4'd12;
    fifo_rd_data_i = 32'hFEDC_BA98;
    wait_flush("ovr", 1);
    start_drain("ovr");
    expect_beats("ovr", 32'hFEDC_BA98, 8);
    check_eq("ovr_cnt", 32'(flush_cnt_o), 32'd5);

    // Zero latched count: count drops to 0 during the FLUSH cycle
    fifo_empty_i   = 1'b0;
    fifo_curr_i    = 4'd4;
    fifo_rd_data_i = 32'hFFFF_FFFF;
    wait_flush("zero", 1);
    fifo_empty_i = 1'b1;
    fifo_curr_i  = 4'd0;
    seen = 1'b0;
    repeat (3) begin
      tick();
      if (out_valid_o) seen = 1'b1;
    end
    check_eq("zero_nobeat", 32'(seen), 32'd0);
    check_eq("zero_idle", 32'(busy_o), 32'd0);
    check_eq("zero_cnt", 32'(flush_cnt_o), 32'd6);

    // Reset in the middle of a drain after two beats
    fifo_empty_i   = 1'b0;
    fifo_curr_i    = 4'd4;
    fifo_rd_data_i = 32'h0000_DCBA;
    wait_flush("rmd", 1);
    start_drain("rmd");
    check_eq("rmd_b1", 32'(out_data_o), 32'hA);
    tick();
    check_eq("rmd_b2", 32'(out_data_o), 32'hB);
    tick();
    #2;
    reset = 1'b0;
    #1;
    $display("[TB] rmd reset asserted valid=%b busy=%b cnt=%0d", out_valid_o, busy_o, flush_cnt_o);
    check_eq("rmd_valid", 32'(out_valid_o), 32'd0);
    check_eq("rmd_data", 32'(out_data_o), 32'd0);
    check_eq("rmd_last", 32'(out_last_o), 32'd0);
    check_eq("rmd_flush", 32'(fifo_flush_o), 32'd0);
    check_eq("rmd_busy", 32'(busy_o), 32'd0);
    check_eq("rmd_cnt", 32'(flush_cnt_o), 32'd0);
    tick();
    reset = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      tick();
      if (out_valid_o || fifo_flush_o) seen = 1'b1;
    end
    check_eq("rmd_after", 32'(seen), 32'd0);
    check_eq("rmd_after_busy", 32'(busy_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
